// File: rtl/tff_counter_updown.sv
// Up/down modulo counter built from a bank of T flip-flops, with load, wrap/saturate and event flags.
// Optional feature: define TFF_COUNT_EDGE_EN to step once per rising edge of i_en instead of per level.
module tff_counter_updown #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_sat
);

  // Limits carried in WIDTH+1 bits so MODULUS == 2**WIDTH does not overflow.
  localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MOD_M1 = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_sat;
  logic             w_step;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_t;
  logic             w_wrap_next;
  logic             w_sat_next;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_load_ext;

`ifdef TFF_COUNT_EDGE_EN
  logic r_en_d;

  // Delayed enable for rising-edge detection; always tracks i_en.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en_d <= 1'b0;
    end else begin
      r_en_d <= i_en;
    end
  end

  assign w_step = i_en & ~r_en_d;
`else
  assign w_step = i_en;
`endif

  assign w_q_ext    = {1'b0, r_q};
  assign w_load_ext = {1'b0, i_load_val};
  assign w_inc      = w_q_ext + (WIDTH+1)'(1);

  // Next-state selection: load over step over hold.
  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    w_sat_next  = 1'b0;
    if (i_load) begin
      if (w_load_ext >= MOD_W) begin
        w_q_next = MOD_M1[WIDTH-1:0];
      end else begin
        w_q_next = i_load_val;
      end
    end else if (w_step) begin
      if (i_up) begin
        if (w_q_ext == MOD_M1) begin
          if (SATURATE != 0) begin
            w_sat_next = 1'b1;
          end else begin
            w_q_next    = {WIDTH{1'b0}};
            w_wrap_next = 1'b1;
          end
        end else begin
          w_q_next = w_inc[WIDTH-1:0];
        end
      end else begin
        if (r_q == {WIDTH{1'b0}}) begin
          if (SATURATE != 0) begin
            w_sat_next = 1'b1;
          end else begin
            w_q_next    = MOD_M1[WIDTH-1:0];
            w_wrap_next = 1'b1;
          end
        end else begin
          w_q_next = r_q - WIDTH'(1);
        end
      end
    end else begin
      w_q_next = r_q;
    end
  end

  // Only bits whose toggle is set change state.
  assign w_t = r_q ^ w_q_next;

  // T flip-flop bank and registered event flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q    <= {WIDTH{1'b0}};
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      r_q    <= r_q ^ w_t;
      r_wrap <= w_wrap_next;
      r_sat  <= w_sat_next;
    end
  end

  assign o_q    = r_q;
  assign o_wrap = r_wrap;
  assign o_sat  = r_sat;
  assign o_tc   = (i_up & (w_q_ext == MOD_M1)) | (~i_up & (r_q == {WIDTH{1'b0}}));

endmodule

// File: tb/tb_tff_counter_updown.sv
// Directed self-checking bench: one wrapping and one saturating instance driven in parallel.
module tb_tff_counter_updown;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q_w, q_s;
  logic       tc_w, tc_s, wrap_w, wrap_s, sat_w, sat_s;

  int n_checks;
  int n_errors;

  tff_counter_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load), .i_load_val(load_val),
    .o_q(q_w), .o_tc(tc_w), .o_wrap(wrap_w), .o_sat(sat_w)
  );

  tff_counter_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load), .i_load_val(load_val),
    .o_q(q_s), .o_tc(tc_s), .o_wrap(wrap_s), .o_sat(sat_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; up = 1'b1; load_val = 4'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b1; up = 1'b1; load_val = 4'd5;
    tick();
    tick();
    n_checks++;
    if (q_w !== 4'd0) begin n_errors++; $display("FAIL reset_q got %0d exp 0", q_w); end
    n_checks++;
    if ({wrap_w, sat_w, tc_w} !== 3'b000) begin n_errors++; $display("FAIL reset_flags got %b exp 000", {wrap_w, sat_w, tc_w}); end
    n_checks++;
    if ({q_s, wrap_s, sat_s, tc_s} !== 7'd0) begin n_errors++; $display("FAIL reset_sat_inst got %b exp 0", {q_s, wrap_s, sat_s, tc_s}); end
    rst = 1'b0; en = 1'b0; load = 1'b0;
  endtask

  task automatic test_count_up();
    logic [3:0] exp_q [12];
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (q_w !== exp_q[i]) begin n_errors++; $display("FAIL up_q[%0d] got %0d exp %0d", i, q_w, exp_q[i]); end
      n_checks++;
      if (wrap_w !== (i == 9)) begin n_errors++; $display("FAIL up_wrap[%0d] got %b exp %b", i, wrap_w, (i == 9)); end
    end
    en = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({q_w, wrap_w} !== {4'd2, 1'b0}) begin n_errors++; $display("FAIL hold got q=%0d wrap=%b exp q=2 wrap=0", q_w, wrap_w); end
  endtask

  task automatic test_down_wrap_sat();
    do_reset();
    up = 1'b0; en = 1'b1;
    tick();
    n_checks++;
    if ({q_w, wrap_w} !== {4'd9, 1'b1}) begin n_errors++; $display("FAIL down_wrap got q=%0d wrap=%b exp q=9 wrap=1", q_w, wrap_w); end
    n_checks++;
    if ({q_s, sat_s, wrap_s} !== {4'd0, 1'b1, 1'b0}) begin n_errors++; $display("FAIL down_sat1 got q=%0d sat=%b wrap=%b exp 0 1 0", q_s, sat_s, wrap_s); end
    tick();
    n_checks++;
    if ({q_w, wrap_w} !== {4'd8, 1'b0}) begin n_errors++; $display("FAIL down_step got q=%0d wrap=%b exp q=8 wrap=0", q_w, wrap_w); end
    n_checks++;
    if ({q_s, sat_s, wrap_s} !== {4'd0, 1'b1, 1'b0}) begin n_errors++; $display("FAIL down_sat2 got q=%0d sat=%b wrap=%b exp 0 1 0", q_s, sat_s, wrap_s); end
    en = 1'b0;
    tick();
    n_checks++;
    if (sat_s !== 1'b0) begin n_errors++; $display("FAIL sat_clear got %b exp 0", sat_s); end
  endtask

  task automatic test_load_clamp();
    do_reset();
    load = 1'b1; load_val = 4'd13; en = 1'b1; up = 1'b1;
    tick();
    n_checks++;
    if ({q_w, wrap_w, tc_w} !== {4'd9, 1'b0, 1'b1}) begin n_errors++; $display("FAIL load_clamp got q=%0d wrap=%b tc=%b exp 9 0 1", q_w, wrap_w, tc_w); end
    load = 1'b0;
    tick();
    n_checks++;
    if ({q_w, wrap_w} !== {4'd0, 1'b1}) begin n_errors++; $display("FAIL load_then_wrap got q=%0d wrap=%b exp 0 1", q_w, wrap_w); end
    n_checks++;
    if ({q_s, sat_s} !== {4'd9, 1'b1}) begin n_errors++; $display("FAIL load_then_sat got q=%0d sat=%b exp 9 1", q_s, sat_s); end
    en = 1'b0;
  endtask

  task automatic test_reset_priority_tc();
    do_reset();
    load = 1'b1; load_val = 4'd5;
    tick();
    n_checks++;
    if (q_w !== 4'd5) begin n_errors++; $display("FAIL load5 got %0d exp 5", q_w); end
    rst = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1;
    tick();
    n_checks++;
    if (q_w !== 4'd0) begin n_errors++; $display("FAIL rst_over_load got %0d exp 0", q_w); end
    rst = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'd9; up = 1'b1;
    tick();
    n_checks++;
    if (tc_w !== 1'b1) begin n_errors++; $display("FAIL tc_q9_up got %b exp 1", tc_w); end
    up = 1'b0; #1;
    n_checks++;
    if (tc_w !== 1'b0) begin n_errors++; $display("FAIL tc_q9_down got %b exp 0", tc_w); end
    load_val = 4'd0;
    tick();
    n_checks++;
    if (tc_w !== 1'b1) begin n_errors++; $display("FAIL tc_q0_down got %b exp 1", tc_w); end
    up = 1'b1; #1;
    n_checks++;
    if (tc_w !== 1'b0) begin n_errors++; $display("FAIL tc_q0_up got %b exp 0", tc_w); end
    load = 1'b0;
  endtask

  task automatic test_edge_en();
    logic [3:0] exp_mid, exp_end;
`ifdef TFF_COUNT_EDGE_EN
    exp_mid = 4'd1; exp_end = 4'd2;
`else
    exp_mid = 4'd5; exp_end = 4'd6;
`endif
    do_reset();
    up = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (q_w !== exp_mid) begin n_errors++; $display("FAIL en_held got %0d exp %0d", q_w, exp_mid); end
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    n_checks++;
    if (q_w !== exp_end) begin n_errors++; $display("FAIL en_pulses got %0d exp %0d", q_w, exp_end); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
    test_reset();
    test_count_up();
    test_down_wrap_sat();
    test_load_clamp();
    test_reset_priority_tc();
    test_edge_en();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
